// File: rtl/aes_pkg.sv
// AES-128 forward-cipher constants and byte/word/state transforms.
// State vectors are [127:0] with byte 0 in bits [127:120]; byte i sits at row i%4, col i/4.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aes_fsm_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r moves left by r columns: out(r,c) = in(r,(c+r)%4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational AES-128 key schedule: 128-bit key -> 44 words, w[0] in bits [1407:1376].
module aes_key_expand (
  input  logic [127:0]  key,
  output logic [1407:0] words
);
  import aes_pkg::*;

  logic [31:0] words_s [0:43];

  // Expand the key word by word, then pack with w[0] at the top.
  always_comb begin
    words = 1408'h0;
    for (int i = 0; i < NK; i++) words_s[i] = key[127-32*i -: 32];
    for (int i = NK; i < 44; i++) begin
      if ((i % NK) == 0) begin
        words_s[i] = words_s[i-NK] ^ sub_word(rot_word(words_s[i-1])) ^ {rcon(4'(i / NK)), 24'h000000};
      end else begin
        words_s[i] = words_s[i-NK] ^ words_s[i-1];
      end
    end
    for (int i = 0; i < 44; i++) words[1407-32*i -: 32] = words_s[i];
  end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption engine: one round per clock, 11 cycles per block.
module aes128_encrypt_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] in_block,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_block
);
  import aes_pkg::*;

  aes_fsm_e      fsm_r, fsm_nxt_s;
  logic [3:0]    round_r, round_nxt_s;
  logic [127:0]  blk_r, blk_nxt_s;
  logic [127:0]  key_r, key_nxt_s;
  logic [127:0]  out_r, out_nxt_s;
  logic          done_r, done_nxt_s;
  logic [1407:0] round_keys_s;
  logic [127:0]  rk_s;
  logic [127:0]  sub_shift_s;

  aes_key_expand u_key_expand (
    .key   (key_r),
    .words (round_keys_s)
  );

  // Round-key select by round number; round 0 is applied straight from the key input.
  always_comb begin
    case (round_r)
      4'd1:    rk_s = round_keys_s[1279:1152];
      4'd2:    rk_s = round_keys_s[1151:1024];
      4'd3:    rk_s = round_keys_s[1023:896];
      4'd4:    rk_s = round_keys_s[895:768];
      4'd5:    rk_s = round_keys_s[767:640];
      4'd6:    rk_s = round_keys_s[639:512];
      4'd7:    rk_s = round_keys_s[511:384];
      4'd8:    rk_s = round_keys_s[383:256];
      4'd9:    rk_s = round_keys_s[255:128];
      4'd10:   rk_s = round_keys_s[127:0];
      default: rk_s = 128'h0;
    endcase
  end

  // The 16 state S-boxes are shared by the full rounds and the final round.
  assign sub_shift_s = shift_rows(sub_bytes(blk_r));

  // Sequencing: accept a block when idle, step one round per cycle, publish on the last.
  always_comb begin
    fsm_nxt_s   = fsm_r;
    round_nxt_s = round_r;
    blk_nxt_s   = blk_r;
    key_nxt_s   = key_r;
    out_nxt_s   = out_r;
    done_nxt_s  = 1'b0;
    case (fsm_r)
      ST_IDLE: begin
        if (start) begin
          key_nxt_s   = key;
          blk_nxt_s   = in_block ^ key;
          round_nxt_s = 4'd1;
          fsm_nxt_s   = ST_RUN;
        end else begin
          fsm_nxt_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (round_r == 4'(NR)) begin
          out_nxt_s   = sub_shift_s ^ rk_s;
          done_nxt_s  = 1'b1;
          round_nxt_s = 4'd0;
          fsm_nxt_s   = ST_IDLE;
        end else begin
          blk_nxt_s   = mix_columns(sub_shift_s) ^ rk_s;
          round_nxt_s = round_r + 4'd1;
        end
      end
      default: fsm_nxt_s = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r   <= ST_IDLE;
      round_r <= 4'd0;
      blk_r   <= 128'h0;
      key_r   <= 128'h0;
      out_r   <= 128'h0;
      done_r  <= 1'b0;
    end else begin
      fsm_r   <= fsm_nxt_s;
      round_r <= round_nxt_s;
      blk_r   <= blk_nxt_s;
      key_r   <= key_nxt_s;
      out_r   <= out_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign busy      = (fsm_r == ST_RUN);
  assign done      = done_r;
  assign out_block = out_r;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed and randomized bench for aes128_encrypt_core against a GF(2^8)-derived reference.
module tb_aes128_encrypt_core;

  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] in_block, key;
  logic         busy, done;
  logic [127:0] out_block;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];

  aes128_encrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_block  (in_block),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .out_block (out_block)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return gmul_ret(p);
  endfunction

  function automatic logic [7:0] gmul_ret(input logic [7:0] p);
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r+4*c] = sb[st[r+4*((c+r)%4)]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = tmp[r+4*c];
          for (int r = 0; r < 4; r++)
            tmp[r+4*c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    res = 128'h0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called between edges; the next rising edge samples start.
  task automatic launch(input logic [127:0] pt, input logic [127:0] k);
    in_block = pt; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_block = rnd128(); key = rnd128();
  endtask

  task automatic wait_done(input bit noise, output int cnt, output logic got);
    cnt = 0; got = 1'b0;
    while (cnt < 30 && !got) begin
      @(posedge clk); #1;
      cnt++;
      if (done) got = 1'b1;
      else if (noise) begin
        start = ($urandom_range(0, 2) == 0);
        in_block = rnd128(); key = rnd128();
      end
    end
    start = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input string tag, input bit noise);
    int   cnt;
    logic got;
    launch(pt, k);
    chk({tag, "_busy_hi"}, 128'(busy), 128'd1);
    wait_done(noise, cnt, got);
    chk({tag, "_done_seen"}, 128'(got), 128'd1);
    chk({tag, "_edges"}, 128'(cnt + 1), 128'd11);
    chk({tag, "_out"}, out_block, exp);
    chk({tag, "_busy_lo"}, 128'(busy), 128'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 128'(done), 128'd0);
    chk({tag, "_out_held"}, out_block, exp);
  endtask

  initial begin
    int         cnt, pulses, first;
    logic       got;
    logic [127:0] pt, k;
    rst_n = 1'b0; start = 1'b0; in_block = 128'h0; key = 128'h0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out_block, 128'h0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_block(V1_PT, V1_KEY, V1_CT, "vec1", 1'b0);
    chk("vec1_rk10", dut.round_keys_s[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    run_block(V2_PT, V2_KEY, V2_CT, "vec2", 1'b0);
    chk("vec2_w40_43", dut.round_keys_s[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_block(128'h0, 128'h0, Z_CT, "zero", 1'b0);

    // Start pulse while busy must be ignored.
    launch(V2_PT, V2_KEY);
    pulses = 0; first = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 4) begin
        in_block = V1_PT; key = V1_KEY; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_start_pulses", 128'(pulses), 128'd1);
    chk("busy_start_edges", 128'(first + 1), 128'd11);
    chk("busy_start_out", out_block, V2_CT);

    // Reset in the middle of a block.
    launch(V1_PT, V1_KEY);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst_out", out_block, 128'h0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("midrst_no_done", 128'(pulses), 128'd0);
    run_block(V1_PT, V1_KEY, V1_CT, "after_rst", 1'b0);

    // Back-to-back: next start raised in the done cycle.
    launch(V1_PT, V1_KEY);
    wait_done(1'b0, cnt, got);
    chk("b2b_first_out", out_block, V1_CT);
    launch(V2_PT, V2_KEY);
    chk("b2b_busy", 128'(busy), 128'd1);
    wait_done(1'b0, cnt, got);
    chk("b2b_second_seen", 128'(got), 128'd1);
    chk("b2b_second_edges", 128'(cnt + 1), 128'd11);
    chk("b2b_second_out", out_block, V2_CT);
    @(negedge clk);

    for (int n = 0; n < 12; n++) begin
      pt = rnd128(); k = rnd128();
      run_block(pt, k, ref_encrypt(pt, k), $sformatf("rand%0d", n), n[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
